// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR block.
// This package provides the default parameters, the legal width range and the
// maximal-length tap masks for every supported width.
package lfsr_pkg;

  localparam int unsigned LFSR_DEFAULT_WIDTH = 8;
  localparam logic [31:0] LFSR_DEFAULT_SEED  = 32'h0000_0001;
  localparam int unsigned LFSR_MIN_WIDTH     = 3;
  localparam int unsigned LFSR_MAX_WIDTH     = 32;

  // Tap mask for a Fibonacci LFSR that shifts toward the MSB.
  // Bit k of the mask set means state bit k feeds the XOR that produces the new LSB.
  // For polynomial x^n + x^a + ... + 1, the set bits are (n-1), (a-1), ...
  // Every entry is a maximal-length polynomial, so the period is 2^width - 1.
  // An unsupported width returns 0, and the top level rejects such widths.
  function automatic logic [31:0] taps(input int unsigned width);
    logic [31:0] mask;
    case (width)
      3:       mask = 32'h0000_0006; // x^3+x^2+1
      4:       mask = 32'h0000_000C; // x^4+x^3+1
      5:       mask = 32'h0000_0014; // x^5+x^3+1
      6:       mask = 32'h0000_0030; // x^6+x^5+1
      7:       mask = 32'h0000_0060; // x^7+x^6+1
      8:       mask = 32'h0000_00B8; // x^8+x^6+x^5+x^4+1
      9:       mask = 32'h0000_0110; // x^9+x^5+1
      10:      mask = 32'h0000_0240; // x^10+x^7+1
      11:      mask = 32'h0000_0500; // x^11+x^9+1
      12:      mask = 32'h0000_0829; // x^12+x^6+x^4+x+1
      13:      mask = 32'h0000_100D; // x^13+x^4+x^3+x+1
      14:      mask = 32'h0000_2015; // x^14+x^5+x^3+x+1
      15:      mask = 32'h0000_6000; // x^15+x^14+1
      16:      mask = 32'h0000_D008; // x^16+x^15+x^13+x^4+1
      17:      mask = 32'h0001_2000; // x^17+x^14+1
      18:      mask = 32'h0002_0400; // x^18+x^11+1
      19:      mask = 32'h0004_0023; // x^19+x^6+x^2+x+1
      20:      mask = 32'h0009_0000; // x^20+x^17+1
      21:      mask = 32'h0014_0000; // x^21+x^19+1
      22:      mask = 32'h0030_0000; // x^22+x^21+1
      23:      mask = 32'h0042_0000; // x^23+x^18+1
      24:      mask = 32'h00E1_0000; // x^24+x^23+x^22+x^17+1
      25:      mask = 32'h0120_0000; // x^25+x^22+1
      26:      mask = 32'h0200_0023; // x^26+x^6+x^2+x+1
      27:      mask = 32'h0400_0013; // x^27+x^5+x^2+x+1
      28:      mask = 32'h0900_0000; // x^28+x^25+1
      29:      mask = 32'h1400_0000; // x^29+x^27+1
      30:      mask = 32'h2000_0029; // x^30+x^6+x^4+x+1
      31:      mask = 32'h4800_0000; // x^31+x^28+1
      32:      mask = 32'h8020_0003; // x^32+x^22+x^2+x+1
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Maximal-length Fibonacci LFSR.
// While i_enable is high, the state shifts toward the MSB on each rising clock edge,
// and the XOR of the tapped bits enters at the LSB.
// If the state ever reaches the all-zero lock-up value, the next edge reloads SEED,
// whatever the value of i_enable.
// o_value is the state register itself, so a step appears one edge after the enable is sampled.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_DEFAULT_WIDTH,
  parameter logic [31:0] SEED  = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_value
);

  localparam logic [31:0]      TAP_MASK_FULL = taps(WIDTH);
  localparam logic [WIDTH-1:0] TAP_MASK      = TAP_MASK_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W        = SEED[WIDTH-1:0];

  // Reject illegal configurations when the design is elaborated.
  if ((WIDTH < LFSR_MIN_WIDTH) || (WIDTH > LFSR_MAX_WIDTH)) begin : g_bad_width
    $error("lfsr: WIDTH=%0d is outside the range %0d..%0d", WIDTH, LFSR_MIN_WIDTH, LFSR_MAX_WIDTH);
  end
  if (SEED == 32'h0) begin : g_zero_seed
    $error("lfsr: SEED must be nonzero");
  end
  if ((WIDTH < 32) && ((SEED >> WIDTH) != 32'h0)) begin : g_wide_seed
    $error("lfsr: SEED=0x%0h does not fit in WIDTH=%0d bits", SEED, WIDTH);
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             feedback;
  logic             lockup;

  // Compute the next state.
  // Recovery from lock-up takes priority over the enable.
  // In simulation, an unknown enable falls through to the hold branch.
  always_comb begin
    feedback = ^(state_q & TAP_MASK);
    lockup   = (state_q == '0);
    state_d  = state_q;
    if (lockup) begin
      state_d = SEED_W;
    end else if (i_enable) begin
      state_d = {state_q[WIDTH-2:0], feedback};
    end
  end

  // State register. Asserting reset forces SEED immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_W;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_value = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Testbench for the LFSR.
// The driver issues one enable decision per cycle and pushes the expected next state.
// A separate monitor pops one entry after each rising edge and compares it with the output.
// The reference model works from the stated feedback rule: fb = s[7]^s[5]^s[4]^s[3], shifted in at the LSB.
module tb_lfsr;

  localparam logic [7:0]  SEED8  = 8'h01;
  localparam logic [15:0] SEED16 = 16'h0001;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [7:0]  o_value;
  logic        en16 = 1'b0;
  logic [15:0] val16;

  always #5 clk = ~clk;

  lfsr #(.WIDTH(8), .SEED(32'h1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (i_enable),
    .o_value  (o_value)
  );

  lfsr #(.WIDTH(16), .SEED(32'h1)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (en16),
    .o_value  (val16)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit         capture = 1'b0;
  logic [7:0] model_s;
  logic [7:0] mon_exp;
  logic [7:0] period_seq [0:299];

  // Behavioural next-state rule for WIDTH=8.
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    int tap_bits[4] = '{7, 5, 4, 3};
    int ones;
    if (s == 8'h00) return SEED8;
    ones = 0;
    foreach (tap_bits[k]) if (s[tap_bits[k]]) ones++;
    return (s << 1) | 8'(ones % 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en);
    @(negedge clk);
    i_enable = en;
    if (en || model_s == 8'h00) model_s = ref_next(model_s);
    exp_q.push_back(model_s);
  endtask

  task automatic drain();
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    rst_n    = 1'b0;
    model_s  = SEED8;
    @(negedge clk);
    chk("reset_value", o_value, SEED8);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (o_value !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard: o_value=%02h expected=%02h", o_value, mon_exp);
      end
      if (capture) obs_q.push_back(o_value);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] lit [0:6];
    bit         seen [0:255];
    bit         seen16 [0:65535];
    int         dups, zeros, rep_bad, count;

    // Reset held for 3 clocks with i_enable left unassigned, then 10 disabled cycles.
    rst_n   = 1'b0;
    model_s = SEED8;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", o_value, SEED8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("x_enable_hold", o_value, SEED8);
    repeat (10) drive(1'b0);
    drain();

    // First seven steps against the literal sequence.
    lit = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    obs_q.delete();
    capture = 1'b1;
    repeat (7) drive(1'b1);
    drain();
    capture = 1'b0;
    chk("seq7_len", obs_q.size(), 7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++) chk("seq7_literal", obs_q[i], lit[i]);

    // 300 enabled edges from reset: check the period and the wrap-around.
    do_reset();
    obs_q.delete();
    capture = 1'b1;
    repeat (300) drive(1'b1);
    drain();
    capture = 1'b0;
    chk("period_len", obs_q.size(), 300);
    for (int i = 0; i < 300; i++) period_seq[i] = (i < obs_q.size()) ? obs_q[i] : 8'h00;
    dups  = 0;
    zeros = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (period_seq[i] == 8'h00) zeros++;
      if (seen[period_seq[i]]) dups++;
      seen[period_seq[i]] = 1'b1;
    end
    chk("period_no_repeat", dups, 0);
    chk("period_no_zero", zeros, 0);
    chk("wrap_to_seed", period_seq[254], SEED8);
    rep_bad = 0;
    for (int i = 0; i < 45; i++) if (period_seq[i + 255] != period_seq[i]) rep_bad++;
    chk("wrap_repeats", rep_bad, 0);

    // Alternate the enable: 150 steps in 300 cycles.
    do_reset();
    for (int i = 0; i < 300; i++) drive((i % 2) == 0);
    drain();
    chk("toggle_150_steps", o_value, period_seq[149]);

    // Random enable pattern.
    for (int i = 0; i < 200; i++) drive(1'($urandom_range(0, 1)));
    drain();

    // Reset asserted mid-cycle after 40 steps.
    do_reset();
    repeat (40) drive(1'b1);
    drain();
    chk("before_async_reset", o_value, period_seq[39]);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", o_value, SEED8);
    @(posedge clk);
    #1;
    chk("reset_ignores_enabled_edge", o_value, SEED8);
    @(negedge clk);
    i_enable = 1'b0;
    rst_n    = 1'b1;
    model_s  = SEED8;
    drive(1'b1);
    drive(1'b1);
    drain();
    chk("restart_after_reset", o_value, 8'h04);

    // Lock-up recovery, once with the enable low and once with it high.
    for (int pass = 0; pass < 2; pass++) begin
      i_enable = 1'b0;
      force dut.state_q = 8'h00;
      #1;
      release dut.state_q;
      #1;
      chk("forced_zero", o_value, 8'h00);
      model_s = 8'h00;
      drive(pass == 1);
      drain();
      chk("lockup_recovery", o_value, SEED8);
    end

    // WIDTH=16 instance: the full period must be 65535 distinct nonzero values.
    i_enable = 1'b0;
    chk("w16_start", val16, SEED16);
    foreach (seen16[i]) seen16[i] = 1'b0;
    dups  = 0;
    zeros = 0;
    count = 0;
    @(negedge clk);
    en16 = 1'b1;
    while (count < 70000) begin
      @(negedge clk);
      count++;
      if (val16 == 16'h0000) zeros++;
      if (seen16[val16]) dups++;
      seen16[val16] = 1'b1;
      if (val16 == SEED16) break;
    end
    en16 = 1'b0;
    chk("w16_period", count, 65535);
    chk("w16_no_zero", zeros, 0);
    chk("w16_no_repeat", dups, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-002 Parameter WIDTH, default 8: LFSR register and output width; legal range 3..32.
REQ-003 Parameter SEED, default 1 (8'h01 at WIDTH=8): reset and lock-up recovery value; must be nonzero.
REQ-004 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_enable, input, 1 bit: advances the LFSR by one step per rising clk edge while high.
REQ-007 Port o_value, output, WIDTH bits: current LFSR state, driven directly from the state register.

Function
REQ-008 The LFSR SHALL be Fibonacci type; each step shifts left (state <= {state[WIDTH-2:0], fb}).
REQ-009 fb SHALL be the XOR of the state bits at the tap positions of a maximal-length polynomial for WIDTH.
- WIDTH=8: x^8+x^6+x^5+x^4+1.
- fb = s[7]^s[5]^s[4]^s[3].
REQ-010 For every legal WIDTH, the sequence period SHALL be 2^WIDTH-1; it visits every nonzero value exactly once per period.
REQ-011 With i_enable=1 at a rising edge, o_value SHALL hold the next state after that edge; latency is one cycle and there is no pipeline.
REQ-012 With i_enable=0 at a rising edge, o_value SHALL hold its value.
REQ-013 i_enable is sampled only at rising edges; it may change asynchronously between edges without glitching o_value.
REQ-014 If the state is ever all-zeros (lock-up), the next edge SHALL load SEED regardless of i_enable.
REQ-015 At WIDTH=8 and SEED=8'h01, the sequence after reset SHALL be 01, 02, 04, 08, 11, 23, 47, 8E, ...
REQ-016 At wrap-around, the state 255 steps after SEED SHALL equal SEED, with no extra or skipped cycle.
REQ-017 o_value SHALL never be X after reset, including while i_enable is undriven before its first assignment.
- Treat X on i_enable as hold.
- This requirement applies in simulation only.

Reset
REQ-018 While rst_n=0, the state and o_value SHALL be SEED immediately, asynchronously, independent of clk and i_enable.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence; after rst_n rises, stepping restarts from SEED on the first enabled edge.
REQ-020 Reset release SHALL be edge-safe: the first edge with rst_n=1 and i_enable=1 produces SEED's successor (02 at the defaults).

Structure
REQ-021 A shared package lfsr_pkg SHALL hold the tap-mask lookup function.
- Signature: taps(width) returns a 32-bit mask.
- One entry per WIDTH 3..32, each a maximal-length polynomial.
- The package SHALL also hold constants for default WIDTH/SEED.
REQ-022 The module SHALL contain one state register with combinational feedback computed as the XOR-reduction of (state & mask).
REQ-023 No sub-module is required; the feedback is inline.
REQ-024 An elaboration-time check SHALL reject SEED==0, WIDTH outside 3..32, and SEED wider than WIDTH.

Verification
REQ-025 Scenario: rst_n=0 for 3 clocks, i_enable=0 -> o_value=01 during reset and while i_enable stays low for 10 cycles after release.
REQ-026 Scenario: i_enable=1 for 7 edges from reset -> o_value steps 02, 04, 08, 11, 23, 47, 8E, one value per edge.
REQ-027 Scenario: i_enable=1 for 300 edges -> no value repeats within the first 255 and none is 00; o_value=01 after edge 255, and edges 256+ repeat the sequence.
REQ-028 Scenario: toggle i_enable 1/0 on alternate cycles -> o_value advances only on enabled edges, 150 steps in 300 cycles.
REQ-029 Scenario: assert rst_n=0 asynchronously mid-cycle after 40 steps -> o_value=01 before the next clk edge; after release, the sequence restarts 02, 04, ...
REQ-030 Scenario: force the state to 00 -> next edge yields 01 with i_enable=0 and with i_enable=1; also rerun WIDTH=16 and confirm period 65535.
